// File: rtl/demux8_dispatch.sv
// rtl/demux8_dispatch.sv - registered 1-to-8 beat dispatcher with one-entry hold and drop counter
module demux8_dispatch #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_sel,
    input  logic [7:0]       en_mask,
    input  logic             flush,
    input  logic             clr_drop,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_sel,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] hold_data;
    logic [2:0]       hold_sel;
    logic             full;
    logic             drain;
    logic             accept;
    logic             load;
    logic             drop;

    assign full  = (state == FULL);
    assign drain = full && out_ready[hold_sel];

    // Ready depends combinationally on the held channel's out_ready so a
    // draining beat can be replaced in the same cycle.
    assign in_ready = !flush && (!full || drain);
    assign accept   = in_valid && in_ready;
    assign load     = accept && en_mask[in_sel];
    assign drop     = accept && !en_mask[in_sel];

    assign out_valid = full ? (8'b1 << hold_sel) : 8'b0;
    assign out_data  = hold_data;
    assign out_sel   = hold_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else if (load) begin
            state_next = FULL;
        end else if (drain) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_data <= '0;
            hold_sel  <= '0;
        end else if (load) begin
            hold_data <= in_data;
            hold_sel  <= in_sel;
        end
    end

    // Clear takes precedence over a coincident drop; the count saturates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (clr_drop) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_demux8_dispatch.sv
// tb/tb_demux8_dispatch.sv - directed self-checking bench for demux8_dispatch
module tb_demux8_dispatch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  in_sel;
    logic [7:0]  en_mask;
    logic        flush;
    logic        clr_drop;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_sel;
    logic [7:0]  drop_cnt;

    logic        s_in_ready;
    logic [7:0]  s_out_valid;
    logic [15:0] s_out_data;
    logic [2:0]  s_out_sel;
    logic [1:0]  s_drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux8_dispatch #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .en_mask(en_mask), .flush(flush),
        .clr_drop(clr_drop), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel), .drop_cnt(drop_cnt)
    );

    demux8_dispatch #(.WIDTH(16), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_sel(in_sel), .en_mask(en_mask), .flush(flush),
        .clr_drop(clr_drop), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_sel(s_out_sel), .drop_cnt(s_drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        en_mask   = 8'hFF;
        flush     = 1'b0;
        clr_drop  = 1'b0;
        out_ready = 8'h00;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'h00);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_sel", 32'(out_sel), 32'h0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // single beat
        out_ready = 8'hFF;
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        in_sel    = 3'd5;
        tick();
        in_valid = 1'b0;
        #1;
        chk("single_valid", 32'(out_valid), 32'h20);
        chk("single_data", 32'(out_data), 32'hBEEF);
        chk("single_sel", 32'(out_sel), 32'h5);
        chk("single_in_ready", 32'(in_ready), 32'h1);
        tick();
        chk("single_gone", 32'(out_valid), 32'h00);

        // streaming, one beat per cycle
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_sel   = 3'(i);
            in_data  = 16'(i);
            #1;
            chk($sformatf("stream_in_ready_%0d", i), 32'(in_ready), 32'h1);
            tick();
            chk($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'h1 << i);
            chk($sformatf("stream_data_%0d", i), 32'(out_data), 32'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_end", 32'(out_valid), 32'h00);

        // backpressure on channel 3 while other channels are ready
        out_ready = 8'hF7;
        in_valid  = 1'b1;
        in_sel    = 3'd3;
        in_data   = 16'h1234;
        tick();
        in_sel  = 3'd1;
        in_data = 16'h5555;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("bp_valid_%0d", c), 32'(out_valid), 32'h08);
            chk($sformatf("bp_data_%0d", c), 32'(out_data), 32'h1234);
            chk($sformatf("bp_in_ready_%0d", c), 32'(in_ready), 32'h0);
            tick();
        end
        out_ready = 8'hFF;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("bp_next_valid", 32'(out_valid), 32'h02);
        chk("bp_next_data", 32'(out_data), 32'h5555);
        tick();
        chk("bp_drained", 32'(out_valid), 32'h00);

        // masking and saturation
        en_mask  = 8'hFE;
        in_valid = 1'b1;
        in_sel   = 3'd0;
        in_data  = 16'hDEAD;
        for (int d = 0; d < 3; d++) begin
            tick();
            chk($sformatf("mask_valid_%0d", d), 32'(out_valid), 32'h00);
        end
        chk("mask_cnt3", 32'(drop_cnt), 32'h3);
        chk("mask_sat_cnt3", 32'(s_drop_cnt), 32'h3);
        tick();
        tick();
        chk("mask_cnt5", 32'(drop_cnt), 32'h5);
        chk("mask_sat_cnt_sat", 32'(s_drop_cnt), 32'h3);
        clr_drop = 1'b1;
        tick();
        clr_drop = 1'b0;
        in_valid = 1'b0;
        chk("clr_cnt", 32'(drop_cnt), 32'h0);
        chk("clr_sat_cnt", 32'(s_drop_cnt), 32'h0);
        in_valid = 1'b1;
        tick();
        chk("drop_after_clr", 32'(drop_cnt), 32'h1);
        clr_drop = 1'b1;
        tick();
        clr_drop = 1'b0;
        in_valid = 1'b0;
        chk("clr_wins", 32'(drop_cnt), 32'h0);

        // flush while full
        en_mask   = 8'hFF;
        out_ready = 8'h00;
        in_valid  = 1'b1;
        in_sel    = 3'd2;
        in_data   = 16'h2222;
        tick();
        chk("flush_full", 32'(out_valid), 32'h04);
        flush  = 1'b1;
        in_sel = 3'd4;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'h0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_empty", 32'(out_valid), 32'h00);
        chk("flush_no_count", 32'(drop_cnt), 32'h0);

        // mask cleared while full still delivers
        in_valid = 1'b1;
        in_sel   = 3'd6;
        in_data  = 16'h6666;
        tick();
        in_valid = 1'b0;
        en_mask  = 8'h00;
        tick();
        chk("mask_late_valid", 32'(out_valid), 32'h40);
        out_ready = 8'h40;
        tick();
        chk("mask_late_drained", 32'(out_valid), 32'h00);
        chk("mask_late_no_drop", 32'(drop_cnt), 32'h0);

        // asynchronous reset while full with a nonzero count
        in_valid = 1'b1;
        in_sel   = 3'd1;
        tick();
        chk("pre_rst_cnt", 32'(drop_cnt), 32'h1);
        en_mask   = 8'hFF;
        out_ready = 8'h00;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'h02);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h00);
        chk("async_rst_cnt", 32'(drop_cnt), 32'h0);
        chk("async_rst_data", 32'(out_data), 32'h0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
